// File: rtl/song_autoplay_sequencer.sv
// Plays one song from the song ROM: walks {dur, note} entries of the latched song,
// holding each note for dur ticks followed by a silent gap, until a terminator entry.
module song_autoplay_sequencer #(
    parameter int SONG_W      = 3,
    parameter int ADDR_W      = 8,
    parameter int NOTE_W      = 5,
    parameter int DUR_W       = 4,
    parameter int TICK_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic [4:0]                song_idx_i,
    input  logic                      select_i,
    output logic [SONG_W+ADDR_W-1:0]  rom_addr_o,
    input  logic [DUR_W+NOTE_W-1:0]   rom_data_i,
    output logic [NOTE_W-1:0]         note_out_o,
    output logic [SONG_W-1:0]         cur_song_o,
    output logic                      playing_o,
    output logic                      done_o
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        GAP,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       selPrev_q, selPrev_d;
    logic [SONG_W-1:0]          curSong_q, curSong_d;
    logic [ADDR_W-1:0]          notePtr_q, notePtr_d;
    logic [SONG_W+ADDR_W-1:0]   romAddr_q, romAddr_d;
    logic [NOTE_W-1:0]          noteOut_q, noteOut_d;
    logic                       playing_q, playing_d;
    logic                       done_q, done_d;
    logic [TICK_W-1:0]          tickCnt_q, tickCnt_d;
    logic [DUR_W-1:0]           unitCnt_q, unitCnt_d;
    logic [GAP_W-1:0]           gapCnt_q, gapCnt_d;

    logic [DUR_W-1:0]           romDur;
    logic [NOTE_W-1:0]          romNote;
    logic                       startEdge;
    logic                       unusedIdxBits;

    assign romDur        = rom_data_i[DUR_W+NOTE_W-1:NOTE_W];
    assign romNote       = rom_data_i[NOTE_W-1:0];
    assign startEdge     = enable_i && select_i && !selPrev_q;
    assign unusedIdxBits = ^song_idx_i[4:SONG_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            selPrev_q <= 1'b0;
            curSong_q <= '0;
            notePtr_q <= '0;
            romAddr_q <= '0;
            noteOut_q <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            tickCnt_q <= '0;
            unitCnt_q <= '0;
            gapCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            selPrev_q <= selPrev_d;
            curSong_q <= curSong_d;
            notePtr_q <= notePtr_d;
            romAddr_q <= romAddr_d;
            noteOut_q <= noteOut_d;
            playing_q <= playing_d;
            done_q    <= done_d;
            tickCnt_q <= tickCnt_d;
            unitCnt_q <= unitCnt_d;
            gapCnt_q  <= gapCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        selPrev_d = select_i;
        curSong_d = curSong_q;
        notePtr_d = notePtr_q;
        noteOut_d = noteOut_q;
        playing_d = playing_q;
        done_d    = 1'b0;
        tickCnt_d = tickCnt_q;
        unitCnt_d = unitCnt_q;
        gapCnt_d  = gapCnt_q;

        if (!enable_i) begin
            state_d   = IDLE;
            noteOut_d = '0;
            playing_d = 1'b0;
        end else if (startEdge && state_q != DONE) begin
            // A start edge restarts from any active state; one landing in DONE is dropped.
            state_d   = FETCH;
            curSong_d = song_idx_i[SONG_W-1:0];
            notePtr_d = '0;
            noteOut_d = '0;
            playing_d = 1'b1;
            tickCnt_d = '0;
            unitCnt_d = '0;
            gapCnt_d  = '0;
        end else begin
            case (state_q)
                FETCH: state_d = DECODE;
                DECODE: begin
                    if (rom_data_i == '0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        playing_d = 1'b0;
                        noteOut_d = '0;
                    end else begin
                        state_d   = PLAY;
                        noteOut_d = romNote;
                        unitCnt_d = (romDur == '0) ? DUR_W'(1) : romDur;
                        tickCnt_d = '0;
                    end
                end
                PLAY: begin
                    if (tickCnt_q == TICK_LAST) begin
                        tickCnt_d = '0;
                        if (unitCnt_q <= DUR_W'(1)) begin
                            state_d   = GAP;
                            noteOut_d = '0;
                            gapCnt_d  = '0;
                        end else begin
                            unitCnt_d = unitCnt_q - DUR_W'(1);
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + TICK_W'(1);
                    end
                end
                GAP: begin
                    if (gapCnt_q == GAP_LAST) begin
                        gapCnt_d = '0;
                        // The last ROM word of a song ends it even without a terminator.
                        if (&notePtr_q) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            playing_d = 1'b0;
                        end else begin
                            state_d   = FETCH;
                            notePtr_d = notePtr_q + ADDR_W'(1);
                        end
                    end else begin
                        gapCnt_d = gapCnt_q + GAP_W'(1);
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        romAddr_d = {curSong_d, notePtr_d};
    end

    assign rom_addr_o = romAddr_q;
    assign note_out_o = noteOut_q;
    assign cur_song_o = curSong_q;
    assign playing_o  = playing_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_song_autoplay_sequencer.sv
// Bench for song_autoplay_sequencer: expected per-cycle outputs are derived from the
// ROM contents as a timeline of fetch, note, gap and done phases.
module tb_song_autoplay_sequencer;

    localparam int TICK = 4;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        select;
    logic [4:0]  songIdx;
    logic [10:0] romAddr;
    logic [8:0]  romData;
    logic [4:0]  noteOut;
    logic [2:0]  curSong;
    logic        playing;
    logic        done;

    logic [8:0]  romMem [0:2047];

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [10:0] addr;
        logic [4:0]  note;
        logic [2:0]  song;
        logic        playing;
        logic        done;
    } exp_t;

    exp_t        expQ[$];
    logic [10:0] traceEnd;

    always #5 clk = ~clk;

    always @(posedge clk) romData <= romMem[romAddr];

    song_autoplay_sequencer #(
        .SONG_W(3), .ADDR_W(8), .NOTE_W(5), .DUR_W(4),
        .TICK_CYCLES(TICK), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_i(enable),
        .song_idx_i(songIdx),
        .select_i(select),
        .rom_addr_o(romAddr),
        .rom_data_i(romData),
        .note_out_o(noteOut),
        .cur_song_o(curSong),
        .playing_o(playing),
        .done_o(done)
    );

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkVal({tag, " rom_addr"}, 16'(romAddr), 16'(e.addr));
        checkVal({tag, " note_out"}, 16'(noteOut), 16'(e.note));
        checkVal({tag, " cur_song"}, 16'(curSong), 16'(e.song));
        checkVal({tag, " playing"},  16'(playing), 16'(e.playing));
        checkVal({tag, " done"},     16'(done),    16'(e.done));
    endtask

    function automatic void pushExp(input logic [10:0] a, input logic [4:0] n, input logic [2:0] s,
                                    input logic p, input logic d, input int count);
        exp_t e;
        e.addr = a; e.note = n; e.song = s; e.playing = p; e.done = d;
        repeat (count) expQ.push_back(e);
    endfunction

    // Timeline of one song from the start edge: 2 cycles fetch/decode, TICK*units note, GAP silence.
    function automatic void buildTrace(input logic [2:0] s);
        logic [10:0] a;
        logic [8:0]  w;
        int          u;
        expQ.delete();
        for (int i = 0; i < 256; i++) begin
            a = {s, 8'(i)};
            traceEnd = a;
            pushExp(a, 5'd0, s, 1'b1, 1'b0, 2);
            w = romMem[a];
            if (w == 9'd0) begin
                pushExp(a, 5'd0, s, 1'b0, 1'b1, 1);
                pushExp(a, 5'd0, s, 1'b0, 1'b0, 1);
                return;
            end
            u = (w[8:5] == 4'd0) ? 1 : int'(w[8:5]);
            pushExp(a, w[4:0], s, 1'b1, 1'b0, TICK * u);
            pushExp(a, 5'd0, s, 1'b1, 1'b0, GAP);
            if (i == 255) begin
                pushExp(a, 5'd0, s, 1'b0, 1'b1, 1);
                pushExp(a, 5'd0, s, 1'b0, 1'b0, 1);
            end
        end
    endfunction

    function automatic logic [8:0] randEntry(input int maxDur);
        logic [3:0] d;
        logic [4:0] n;
        d = 4'($urandom_range(0, maxDur));
        n = 5'($urandom_range(0, 31));
        if (d == 4'd0 && n == 5'd0) n = 5'd1;
        return {d, n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n, input bit loseStart, input string tag);
        exp_t e;
        int   k = 0;
        while (expQ.size() > 0 && (n < 0 || k < n)) begin
            tick();
            e = expQ.pop_front();
            checkOutput($sformatf("%s c%0d", tag, k), e);
            select = loseStart && e.done;
            k++;
        end
    endtask

    task automatic applyStimulus(input logic [4:0] idx, input string tag);
        songIdx = idx;
        select  = 1'b1;
        buildTrace(idx[2:0]);
        runCycles(1, 1'b0, {tag, " start"});
    endtask

    task automatic checkIdle(input int n, input logic [2:0] s, input logic [10:0] a, input string tag);
        exp_t e;
        e.addr = a; e.note = 5'd0; e.song = s; e.playing = 1'b0; e.done = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            checkOutput($sformatf("%s idle%0d", tag, k), e);
        end
    endtask

    initial begin
        logic [2:0] s;
        int         len;
        int         rs[5] = '{0, 2, 4, 5, 6};

        for (int i = 0; i < 2048; i++) romMem[i] = 9'd0;
        romMem[11'h300] = {4'd2, 5'd5};
        romMem[11'h301] = 9'd0;
        romMem[11'h100] = {4'd0, 5'd7};
        romMem[11'h101] = {4'd3, 5'd0};
        romMem[11'h102] = randEntry(3);
        romMem[11'h103] = randEntry(3);
        romMem[11'h104] = 9'd0;
        foreach (rs[j]) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) romMem[{3'(rs[j]), 8'(i)}] = randEntry(3);
            romMem[{3'(rs[j]), 8'(len)}] = 9'd0;
        end
        for (int i = 0; i < 256; i++) romMem[{3'd7, 8'(i)}] = randEntry(1);

        rst = 1'b0; enable = 1'b1; select = 1'b0; songIdx = 5'd0;
        checkIdle(2, 3'd0, 11'h000, "reset");
        rst = 1'b1;
        checkIdle(2, 3'd0, 11'h000, "post-reset");

        $display("[TB] song 3: two-unit note then terminator");
        applyStimulus(5'd3, "song3");
        runCycles(-1, 1'b0, "song3");
        checkIdle(3, 3'd3, traceEnd, "song3");

        $display("[TB] song 1 via idx 17, start edge during DONE is lost");
        applyStimulus(5'd17, "song1");
        runCycles(-1, 1'b1, "song1");
        checkIdle(3, 3'd1, traceEnd, "song1 lost");

        $display("[TB] restart mid-PLAY with idx 9");
        applyStimulus(5'd3, "restartA");
        runCycles(4, 1'b0, "restartA");
        applyStimulus(5'd9, "restartB");
        runCycles(-1, 1'b0, "restartB");
        checkIdle(2, 3'd1, traceEnd, "restartB");

        $display("[TB] enable dropped mid-PLAY");
        applyStimulus(5'd3, "abort");
        runCycles(4, 1'b0, "abort");
        enable = 1'b0;
        checkIdle(1, 3'd3, 11'h300, "abort off");
        select = 1'b1;
        checkIdle(1, 3'd3, 11'h300, "abort sel");
        enable = 1'b1;
        checkIdle(4, 3'd3, 11'h300, "abort reen");
        select = 1'b0;
        checkIdle(2, 3'd3, 11'h300, "abort rel");

        $display("[TB] reset during GAP");
        applyStimulus(5'd3, "rstgap");
        runCycles(10, 1'b0, "rstgap");
        rst = 1'b0;
        checkIdle(1, 3'd0, 11'h000, "rstgap rst");
        rst = 1'b1;
        checkIdle(2, 3'd0, 11'h000, "rstgap after");

        $display("[TB] random songs");
        for (int j = 0; j < 6; j++) begin
            s = 3'($urandom_range(0, 6));
            applyStimulus({2'($urandom_range(0, 3)), s}, $sformatf("rand%0d", j));
            runCycles(-1, 1'b0, $sformatf("rand%0d", j));
            checkIdle(2, s, traceEnd, $sformatf("rand%0d", j));
        end

        $display("[TB] song 7: full 256 entries, no wrap");
        applyStimulus(5'd7, "song7");
        runCycles(-1, 1'b0, "song7");
        checkVal("song7 end addr", 16'(traceEnd), 16'h07FF);
        checkIdle(3, 3'd7, 11'h7FF, "song7");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
